// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill and a 1-entry redirect slot.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache_dm #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc_icache_i,
  input  logic        if_req_icache_i,
  input  logic        if_jump_icache_i,
  input  logic        fc_flush_icache_i,
  output logic        icache_busy_fc_o,
  output logic [31:0] icache_inst_o,
  output logic [31:0] icache_pc_o,
  output logic        icache_valid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] icache_hits_o,
  output logic [31:0] icache_misses_o
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic [LINES-1:0] vbit;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES*LINE_WORDS];

  logic [31:0]      miss_pc;
  logic [OFF_W-1:0] beat;
  logic             squash;
  logic             no_install;
  logic [31:0]      crit;
  logic             pend_vld;
  logic [31:0]      pend_pc;
  logic             valid_q;
  logic [31:0]      inst_q;
  logic [31:0]      pc_q;

  // A pending redirect takes priority over the fetch port in IDLE.
  logic             lk_en;
  logic [31:0]      lk_pc;
  logic [OFF_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             hit;

  assign lk_en  = (state == S_IDLE) & (pend_vld | if_req_icache_i);
  assign lk_pc  = pend_vld ? pend_pc : if_pc_icache_i;
  assign lk_off = lk_pc[OFF_W+1:2];
  assign lk_idx = lk_pc[OFF_W+IDX_W+1:OFF_W+2];
  assign lk_tag = lk_pc[31:OFF_W+IDX_W+2];
  assign hit    = vbit[lk_idx] & (tags[lk_idx] == lk_tag) & ~fc_flush_icache_i;

  logic [OFF_W-1:0] m_off;
  logic [IDX_W-1:0] m_idx;
  logic [TAG_W-1:0] m_tag;
  logic             jmp;
  logic             last_beat;
  logic             fill_done;

  assign m_off     = miss_pc[OFF_W+1:2];
  assign m_idx     = miss_pc[OFF_W+IDX_W+1:OFF_W+2];
  assign m_tag     = miss_pc[31:OFF_W+IDX_W+2];
  assign jmp       = if_req_icache_i & if_jump_icache_i;
  assign last_beat = &beat;
  assign fill_done = (state == S_REFILL) & mem_rvalid_i & last_beat;

  assign icache_busy_fc_o = (state == S_REFILL) | (lk_en & ~hit);
  assign mem_req_o        = (state == S_REFILL);
  assign mem_addr_o       = (state == S_REFILL) ? {miss_pc[31:OFF_W+2], beat, 2'b00} : 32'd0;
  assign icache_valid_o   = valid_q & ~((state == S_RESP) & jmp);
  assign icache_inst_o    = inst_q;
  assign icache_pc_o      = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vbit       <= '0;
      miss_pc    <= '0;
      beat       <= '0;
      squash     <= 1'b0;
      no_install <= 1'b0;
      crit       <= '0;
      pend_vld   <= 1'b0;
      pend_pc    <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
    end else begin
      valid_q <= 1'b0;
      if (fc_flush_icache_i) vbit <= '0;
      case (state)
        S_IDLE: begin
          if (lk_en) begin
            pend_vld <= 1'b0;
            if (hit) begin
              valid_q <= 1'b1;
              inst_q  <= data[{lk_idx, lk_off}];
              pc_q    <= lk_pc;
            end else begin
              miss_pc    <= lk_pc;
              beat       <= '0;
              squash     <= 1'b0;
              no_install <= 1'b0;
              state      <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (jmp) begin
            squash   <= 1'b1;
            pend_vld <= 1'b1;
            pend_pc  <= if_pc_icache_i;
          end
          if (fc_flush_icache_i) no_install <= 1'b1;
          if (mem_rvalid_i) begin
            if (beat == m_off) crit <= mem_rdata_i;
            beat <= beat + OFF_W'(1);
            if (last_beat) begin
              if (!no_install && !fc_flush_icache_i) vbit[m_idx] <= 1'b1;
              state <= S_RESP;
              if (!(squash || jmp)) begin
                valid_q <= 1'b1;
                pc_q    <= miss_pc;
                inst_q  <= (beat == m_off) ? mem_rdata_i : crit;
              end
            end
          end
        end
        S_RESP: begin
          // busy is already low here, so a new fetch is parked for the next IDLE lookup
          state <= S_IDLE;
          if (if_req_icache_i) begin
            pend_vld <= 1'b1;
            pend_pc  <= if_pc_icache_i;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_REFILL) && mem_rvalid_i) data[{m_idx, beat}] <= mem_rdata_i;
    if (fill_done) tags[m_idx] <= m_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits   <= '0;
      misses <= '0;
    end else if (lk_en) begin
      if (hit && hits != 32'hFFFF_FFFF) hits <= hits + 32'd1;
      else if (!hit && misses != 32'hFFFF_FFFF) misses <= misses + 32'd1;
    end
  end

  assign icache_hits_o   = hits;
  assign icache_misses_o = misses;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: expected responses and refill beats are queued at stimulus time.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        req = 1'b0;
  logic        jump = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hits;
  logic [31:0] misses;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];
  logic [31:0] exp_beats[$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc_icache_i   (pc_in),
    .if_req_icache_i  (req),
    .if_jump_icache_i (jump),
    .fc_flush_icache_i(flush),
    .icache_busy_fc_o (busy),
    .icache_inst_o    (inst),
    .icache_pc_o      (pc_out),
    .icache_valid_o   (valid),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .icache_hits_o    (hits),
    .icache_misses_o  (misses)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers each beat after lat cycles and checks the beat address order.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_req && !rst) begin
        a = mem_addr;
        if (exp_beats.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("beat_addr", a, exp_beats.pop_front());
        repeat (lat - 1) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = memval(a);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_pc.size() == 0) chk("valid_unexpected", 1, 0);
      else begin
        chk("resp_pc", pc_out, exp_pc.pop_front());
        chk("resp_inst", inst, exp_inst.pop_front());
      end
    end
  end

  task automatic push_line(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) exp_beats.push_back({pc[31:4], 4'h0} + 32'(4 * k));
  endtask

  task automatic push_resp(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_inst.push_back(memval(pc));
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
      if (n > 300) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic do_req(input logic [31:0] pc, input bit miss, input bit fl);
    if (miss) push_line(pc);
    push_resp(pc);
    @(posedge clk); #1;
    req = 1'b1; pc_in = pc; flush = fl;
    @(negedge clk);
    chk("req_busy", {31'b0, busy}, {31'b0, miss});
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    wait_idle();
    chk("beats_done", exp_beats.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_valid"}, {31'b0, valid}, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_pc"}, pc_out, 0);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hits"}, hits, 0);
    chk({tag, "_misses"}, misses, 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // cold miss then hit stream in the same line
    do_req(32'h0, 1, 0);
    for (int i = 1; i <= 3; i++) push_resp(32'(4 * i));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      req = 1'b1; pc_in = 32'(4 * i);
      @(negedge clk);
      chk("hs_busy", {31'b0, busy}, 0);
      if (i > 1) chk("hs_valid", {31'b0, valid}, 1);
    end
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("hs_valid", {31'b0, valid}, 1);
    wait_idle();

    // conflict on index 0
    do_req(32'h100, 1, 0);
    do_req(32'h0, 1, 0);

    // redirect during refill squashes 0x40, installs it, then fetches 0x80
    lat = 3;
    push_line(32'h40);
    @(posedge clk); #1;
    req = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    chk("js_miss_busy", {31'b0, busy}, 1);
    @(posedge clk); #1 req = 1'b0;
    push_line(32'h80);
    push_resp(32'h80);
    repeat (2) @(posedge clk);
    #1;
    req = 1'b1; jump = 1'b1; pc_in = 32'h80;
    @(negedge clk);
    chk("js_jump_busy", {31'b0, busy}, 1);
    @(posedge clk); #1;
    req = 1'b0; jump = 1'b0;
    wait_idle();
    chk("js_beats_done", exp_beats.size(), 0);
    lat = 1;
    do_req(32'h44, 0, 0);
    do_req(32'h88, 0, 0);

    // flush while idle, flush coinciding with a request, flush during refill
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    do_req(32'h0, 1, 0);
    do_req(32'h8, 1, 1);
    lat = 2;
    push_line(32'h20);
    push_resp(32'h20);
    @(posedge clk); #1;
    req = 1'b1; pc_in = 32'h20;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle();
    do_req(32'h20, 1, 0);
    do_req(32'h4, 1, 0);
    do_req(32'h2C, 0, 0);

    // reset during the third beat of a refill
    push_line(32'h60);
    @(posedge clk); #1;
    req = 1'b1; pc_in = 32'h60;
    @(posedge clk); #1 req = 1'b0;
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 32'h68) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("beat2_timeout", 1, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    exp_beats.delete();
    exp_pc.delete();
    exp_inst.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_valid", {31'b0, valid}, 0);
    do_req(32'h0, 1, 0);
    do_req(32'h60, 1, 0);

    chk("resp_left", exp_pc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
